// File: rtl/spi_cmd_pkg.sv
// Shared opcodes and FSM state encoding for the SPI command sequencer.
// SPI_CMD_CSUM_EN adds the trailing checksum state.
package spi_cmd_pkg;

    localparam logic [7:0] OPC_WR_W    = 8'h01;
    localparam logic [7:0] OPC_WR_A    = 8'h02;
    localparam logic [7:0] OPC_START   = 8'h10;
    localparam logic [7:0] OPC_CLR_ERR = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_LEN     = 3'd3,
        ST_DATA    = 3'd4,
`ifdef SPI_CMD_CSUM_EN
        ST_CSUM    = 3'd5,
`endif
        ST_DRAIN   = 3'd6
    } state_t;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// Frames the SPI byte stream into buffer writes and compute-start pulses.
// Define SPI_CMD_CSUM_EN to require an XOR checksum byte after write payloads.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  core_busy,
    output logic                  buf_we,
    output logic                  buf_sel,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0] buf_wdata,
    output logic                  start,
    output logic                  err
);

    localparam logic [DATA_WIDTH-1:0] L_WR_W    = DATA_WIDTH'(OPC_WR_W);
    localparam logic [DATA_WIDTH-1:0] L_WR_A    = DATA_WIDTH'(OPC_WR_A);
    localparam logic [DATA_WIDTH-1:0] L_START   = DATA_WIDTH'(OPC_START);
    localparam logic [DATA_WIDTH-1:0] L_CLR_ERR = DATA_WIDTH'(OPC_CLR_ERR);

    state_t                  r_state;
    logic                    r_wait_cs;
    logic                    r_drop;
    logic                    r_sel;
    logic [DATA_WIDTH-1:0]   r_ahi;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [DATA_WIDTH-1:0]   r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_start;
    logic                    r_err;
`ifdef SPI_CMD_CSUM_EN
    logic [DATA_WIDTH-1:0]   r_csum;
`endif

    logic                    w_byte;
    logic                    w_err_set;
    logic                    w_err_clr;
    logic [2*DATA_WIDTH-1:0] w_addr_full;

    // After reset the stream is ignored until the host closes the frame.
    assign w_byte      = rx_valid & ~cs_n & ~r_wait_cs;
    assign w_addr_full = {r_ahi, rx_data};

    always_comb begin
        w_err_set = 1'b0;
        w_err_clr = 1'b0;
        if (w_byte) begin
            unique case (r_state)
                ST_IDLE: begin
                    case (rx_data)
                        L_WR_W, L_WR_A: w_err_set = core_busy;
                        L_START:        w_err_set = core_busy;
                        L_CLR_ERR:      w_err_clr = 1'b1;
                        default:        w_err_set = 1'b1;
                    endcase
                end
`ifdef SPI_CMD_CSUM_EN
                ST_CSUM: w_err_set = ((r_csum ^ rx_data) != '0);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wait_cs <= 1'b1;
            r_drop    <= 1'b0;
            r_sel     <= 1'b0;
            r_ahi     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_start   <= 1'b0;
            r_err     <= 1'b0;
`ifdef SPI_CMD_CSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_we    <= 1'b0;
            r_start <= 1'b0;
            r_err   <= w_err_set | (r_err & ~w_err_clr);
            if (cs_n) begin
                r_state   <= ST_IDLE;
                r_wait_cs <= 1'b0;
            end else if (w_byte) begin
`ifdef SPI_CMD_CSUM_EN
                r_csum <= (r_state == ST_IDLE) ? rx_data
                                               : (r_csum ^ rx_data);
`endif
                unique case (r_state)
                    ST_IDLE: begin
                        case (rx_data)
                            L_WR_W, L_WR_A: begin
                                r_sel   <= (rx_data == L_WR_A);
                                r_drop  <= core_busy;
                                r_state <= ST_ADDR_HI;
                            end
                            L_START: begin
                                r_start <= ~core_busy;
                                r_state <= ST_DRAIN;
                            end
                            default: r_state <= ST_DRAIN;
                        endcase
                    end
                    ST_ADDR_HI: begin
                        r_ahi   <= rx_data;
                        r_state <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        r_ptr   <= ADDR_WIDTH'(w_addr_full);
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        r_cnt   <= rx_data;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (!r_drop) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_ptr;
                            r_wdata <= rx_data;
                        end
                        r_ptr <= r_ptr + ADDR_WIDTH'(1);
                        r_cnt <= r_cnt - DATA_WIDTH'(1);
                        if (r_cnt == '0) begin
`ifdef SPI_CMD_CSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_DRAIN;
`endif
                        end
                    end
`ifdef SPI_CMD_CSUM_EN
                    ST_CSUM: r_state <= ST_DRAIN;
`endif
                    ST_DRAIN: ;
                endcase
            end
        end
    end

    assign buf_we    = r_we;
    assign buf_sel   = r_sel;
    assign buf_addr  = r_addr;
    assign buf_wdata = r_wdata;
    assign start     = r_start;
    assign err       = r_err;

endmodule
